// File: rtl/matrix_chunk_loader_if.sv
// Bus bundle between the chunk loader, its memory port and the transpose consumer.
interface matrix_chunk_loader_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_MG     = 8,
  parameter int unsigned NUM_PE     = NUM_MG,
  parameter int unsigned ADDR_WIDTH = 64
);

  // chunk request from the controller
  logic                                         start;
  logic                                         start_ctrl;
  logic [ADDR_WIDTH-1:0]                        start_base;
  logic [ADDR_WIDTH-1:0]                        start_chunk;
  logic                                         busy;

  // memory read port, one chunk row per request
  logic                                         rd_req_val;
  logic                                         rd_req_rdy;
  logic [ADDR_WIDTH-1:0]                        rd_req_addr;
  logic                                         rd_resp_val;
  logic [NUM_PE*DATA_WIDTH-1:0]                 rd_resp_data;

  // assembled tile towards the transpose top
  logic                                         out_val;
  logic                                         out_rdy;
  logic                                         out_ctrl;
  logic [ADDR_WIDTH-1:0]                        out_base_addr;
  logic [ADDR_WIDTH-1:0]                        out_chunk_addr;
  logic [0:NUM_MG-1][0:NUM_PE-1][DATA_WIDTH-1:0] out_elements;

  // loader side
  modport master (
    input  start, start_ctrl, start_base, start_chunk,
    output busy,
    output rd_req_val, rd_req_addr,
    input  rd_req_rdy,
    input  rd_resp_val, rd_resp_data,
    output out_val, out_ctrl, out_base_addr, out_chunk_addr, out_elements,
    input  out_rdy
  );

  // controller / memory / consumer side
  modport slave (
    output start, start_ctrl, start_base, start_chunk,
    input  busy,
    input  rd_req_val, rd_req_addr,
    output rd_req_rdy,
    output rd_resp_val, rd_resp_data,
    input  out_val, out_ctrl, out_base_addr, out_chunk_addr, out_elements,
    output out_rdy
  );

endinterface

// File: rtl/matrix_chunk_loader.sv
// Fetches one CHUNK_SIZE x CHUNK_SIZE chunk of a row-major matrix row by row
// and presents it as a tile with its sideband to the transpose datapath.
module matrix_chunk_loader #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_MG     = 8,
  parameter int unsigned NUM_PE     = NUM_MG,
  parameter int unsigned ARR_SIZE   = 8,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned CHUNK_SIZE = 8
) (
  input logic                   clk,
  input logic                   rst,
  matrix_chunk_loader_if.master bus
);

  localparam int unsigned ELEM_BYTES = DATA_WIDTH / 8;
  localparam int unsigned CPR        = ARR_SIZE / CHUNK_SIZE;
  localparam int unsigned CPR_LOG2   = (CPR > 1) ? $clog2(CPR) : 0;
  localparam int unsigned CNT_W      = $clog2(NUM_MG + 1);
  localparam int unsigned IDX_W      = (NUM_MG > 1) ? $clog2(NUM_MG) : 1;

  localparam logic [ADDR_WIDTH-1:0] ROW_STRIDE = ADDR_WIDTH'(ARR_SIZE * ELEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] ROW_SPAN   = ADDR_WIDTH'(CHUNK_SIZE * ARR_SIZE);
  localparam logic [ADDR_WIDTH-1:0] COL_SPAN   = ADDR_WIDTH'(CHUNK_SIZE);
  localparam logic [ADDR_WIDTH-1:0] COL_MASK   = ADDR_WIDTH'(CPR - 1);
  localparam logic [ADDR_WIDTH-1:0] ELEM_SZ    = ADDR_WIDTH'(ELEM_BYTES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    PRESENT = 2'd2
  } state_t;

  state_t                                        state;
  logic                                          busy_q;
  logic                                          req_val_q;
  logic [ADDR_WIDTH-1:0]                         req_addr_q;
  logic [CNT_W-1:0]                              req_cnt;
  logic [CNT_W-1:0]                              rsp_cnt;
  logic                                          out_val_q;
  logic                                          out_ctrl_q;
  logic [ADDR_WIDTH-1:0]                         out_base_q;
  logic [ADDR_WIDTH-1:0]                         out_chunk_q;
  logic [0:NUM_MG-1][0:NUM_PE-1][DATA_WIDTH-1:0] tile_q;

  logic [ADDR_WIDTH-1:0]                         chunk_row_c;
  logic [ADDR_WIDTH-1:0]                         chunk_col_c;
  logic [ADDR_WIDTH-1:0]                         row0_addr_c;
  logic [0:NUM_PE-1][DATA_WIDTH-1:0]             resp_row_c;
  logic [IDX_W-1:0]                              rsp_idx_c;

  // Byte address of the first chunk row; later rows are reached by adding ROW_STRIDE.
  always_comb begin
    chunk_row_c = bus.start_chunk >> CPR_LOG2;
    chunk_col_c = bus.start_chunk & COL_MASK;
    row0_addr_c = bus.start_base + (chunk_row_c * ROW_SPAN + chunk_col_c * COL_SPAN) * ELEM_SZ;
  end

  // Element c of a response row sits at the low end of the bus; the tile row is ascending-indexed.
  for (genvar c = 0; c < NUM_PE; c++) begin : g_unpack
    assign resp_row_c[c] = bus.rd_resp_data[c*DATA_WIDTH +: DATA_WIDTH];
  end

  assign rsp_idx_c = rsp_cnt[IDX_W-1:0];

  // Control FSM, request issue, response capture and tile presentation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      busy_q      <= 1'b0;
      req_val_q   <= 1'b0;
      req_addr_q  <= '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
      out_val_q   <= 1'b0;
      out_ctrl_q  <= 1'b0;
      out_base_q  <= '0;
      out_chunk_q <= '0;
      tile_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= FETCH;
            busy_q      <= 1'b1;
            out_ctrl_q  <= bus.start_ctrl;
            out_base_q  <= bus.start_base;
            out_chunk_q <= bus.start_chunk;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            req_val_q   <= 1'b1;
            req_addr_q  <= row0_addr_c;
          end
        end
        FETCH: begin
          if (req_val_q && bus.rd_req_rdy) begin
            req_cnt    <= req_cnt + CNT_W'(1);
            req_addr_q <= req_addr_q + ROW_STRIDE;
            req_val_q  <= (req_cnt != CNT_W'(NUM_MG - 1));
          end
          if (bus.rd_resp_val && (rsp_cnt < CNT_W'(NUM_MG))) begin
            tile_q[rsp_idx_c] <= resp_row_c;
            rsp_cnt           <= rsp_cnt + CNT_W'(1);
            if (rsp_cnt == CNT_W'(NUM_MG - 1)) begin
              state     <= PRESENT;
              out_val_q <= 1'b1;
              req_val_q <= 1'b0;
            end
          end
        end
        PRESENT: begin
          if (bus.out_rdy) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            out_val_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy_q    <= 1'b0;
          req_val_q <= 1'b0;
          out_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.rd_req_val     = req_val_q;
  assign bus.rd_req_addr    = req_addr_q;
  assign bus.out_val        = out_val_q;
  assign bus.out_ctrl       = out_ctrl_q;
  assign bus.out_base_addr  = out_base_q;
  assign bus.out_chunk_addr = out_chunk_q;
  assign bus.out_elements   = tile_q;

endmodule

// File: tb/tb_matrix_chunk_loader.sv
// Scoreboard bench for matrix_chunk_loader: a memory responder, a request/tile
// monitor popping expected values, and a directed stimulus sequence.
module tb_matrix_chunk_loader;

  localparam int unsigned DW  = 64;
  localparam int unsigned NMG = 8;
  localparam int unsigned ARR = 16;
  localparam int unsigned CS  = 8;
  localparam int unsigned AW  = 64;
  localparam int unsigned EB  = DW / 8;
  localparam logic [AW-1:0] STRIDE = AW'(ARR * EB);

  typedef struct {
    logic          ctrl;
    logic [AW-1:0] base;
    logic [AW-1:0] chunk;
    int            tag;
  } tile_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  int last_resp_cyc = -10;
  always @(posedge clk) cyc <= cyc + 1;

  matrix_chunk_loader_if #(.DATA_WIDTH(DW), .NUM_MG(NMG), .NUM_PE(NMG), .ADDR_WIDTH(AW)) bus ();

  matrix_chunk_loader #(
    .DATA_WIDTH(DW), .NUM_MG(NMG), .NUM_PE(NMG),
    .ARR_SIZE(ARR), .ADDR_WIDTH(AW), .CHUNK_SIZE(CS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [AW-1:0] exp_addr_q[$];
  tile_t         exp_tile_q[$];
  logic [AW-1:0] pend_q[$];
  logic [AW-1:0] cur_row0;
  int            cur_tag;
  logic          stray_req;
  int            n_cmp  = 0;
  int            n_fail = 0;

  function automatic logic [DW-1:0] exp_elem(int tag, int r, int c);
    return {32'(tag), 32'(r * NMG + c)};
  endfunction

  function automatic logic [AW-1:0] addr_model(logic [AW-1:0] base, logic [AW-1:0] chunk, int r);
    logic [AW-1:0] cpr, cr, cc;
    cpr = AW'(ARR / CS);
    cr  = chunk / cpr;
    cc  = chunk % cpr;
    return base + ((cr * AW'(CS) + AW'(r)) * AW'(ARR) + cc * AW'(CS)) * AW'(EB);
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // response latch time, sampled where the DUT samples it
  always @(posedge clk) if (bus.rd_resp_val) last_resp_cyc <= cyc;

  // Memory model: answers each accepted request one cycle later, in order.
  initial begin : responder
    logic [AW-1:0] a;
    int            row;
    bus.rd_resp_val  = 1'b0;
    bus.rd_resp_data = '0;
    forever begin
      @(negedge clk);
      if (stray_req) begin
        bus.rd_resp_val  = 1'b1;
        bus.rd_resp_data = {NMG{64'hDEAD_BEEF_0BAD_F00D}};
      end else if (pend_q.size() > 0) begin
        a   = pend_q.pop_front();
        row = int'((a - cur_row0) / STRIDE);
        bus.rd_resp_val = 1'b1;
        for (int c = 0; c < NMG; c++) bus.rd_resp_data[c*DW +: DW] = exp_elem(cur_tag, row, c);
      end else begin
        bus.rd_resp_val  = 1'b0;
        bus.rd_resp_data = '0;
      end
      if (rst && bus.rd_req_val && bus.rd_req_rdy) pend_q.push_back(bus.rd_req_addr);
    end
  end

  // Monitor: request addresses, address hold under stall, tile contents and handshake timing.
  initial begin : monitor
    logic          prev_stall, prev_oval, prev_ordy;
    logic [AW-1:0] prev_addr;
    tile_t         t;
    logic [0:NMG-1][0:NMG-1][DW-1:0] held;
    int            bad, br, bc;
    prev_stall = 1'b0; prev_oval = 1'b0; prev_ordy = 1'b0; prev_addr = '0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall = 1'b0; prev_oval = 1'b0; prev_ordy = 1'b0;
      end else begin
        if (prev_stall) begin
          check("req_addr_hold", bus.rd_req_addr, prev_addr);
          check("req_val_hold", 64'(bus.rd_req_val), 64'd1);
        end
        if (bus.rd_req_val && bus.rd_req_rdy) begin
          if (exp_addr_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL extra_req: got request 0x%0h expected none", bus.rd_req_addr);
          end else begin
            check("req_addr", bus.rd_req_addr, exp_addr_q.pop_front());
          end
        end
        if (bus.out_val && !prev_oval) begin
          check("out_val_latency", 64'(cyc), 64'(last_resp_cyc + 1));
          if (exp_tile_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL extra_tile: got out_val=1 expected no tile");
          end else begin
            t = exp_tile_q.pop_front();
            bad = 0; br = 0; bc = 0;
            for (int r = 0; r < NMG; r++)
              for (int c = 0; c < NMG; c++)
                if (bus.out_elements[r][c] !== exp_elem(t.tag, r, c)) begin
                  if (bad == 0) begin br = r; bc = c; end
                  bad++;
                end
            n_cmp++;
            if (bad != 0) begin
              n_fail++;
              $display("FAIL tile_data[%0d][%0d]: got 0x%0h expected 0x%0h (%0d bad)",
                       br, bc, bus.out_elements[br][bc], exp_elem(t.tag, br, bc), bad);
            end
            check("out_ctrl", 64'(bus.out_ctrl), 64'(t.ctrl));
            check("out_base_addr", bus.out_base_addr, t.base);
            check("out_chunk_addr", bus.out_chunk_addr, t.chunk);
          end
          held = bus.out_elements;
        end else if (bus.out_val && prev_oval) begin
          n_cmp++;
          if (bus.out_elements !== held) begin
            n_fail++;
            $display("FAIL tile_stable: got changed tile row0[0]=0x%0h expected 0x%0h",
                     bus.out_elements[0][0], held[0][0]);
          end
        end
        if (prev_oval && prev_ordy) begin
          check("out_val_drop", 64'(bus.out_val), 64'd0);
          check("busy_drop", 64'(bus.busy), 64'd0);
        end
        prev_stall = bus.rd_req_val && !bus.rd_req_rdy;
        prev_addr  = bus.rd_req_addr;
        prev_oval  = bus.out_val;
        prev_ordy  = bus.out_rdy;
      end
    end
  end

  task automatic push_model_addrs(logic [AW-1:0] base, logic [AW-1:0] chunk);
    for (int r = 0; r < NMG; r++) exp_addr_q.push_back(addr_model(base, chunk, r));
  endtask

  task automatic issue_start(logic ctrl, logic [AW-1:0] base, logic [AW-1:0] chunk, int tag, bit want_tile);
    tile_t t;
    cur_row0 = addr_model(base, chunk, 0);
    cur_tag  = tag;
    if (want_tile) begin
      t.ctrl = ctrl; t.base = base; t.chunk = chunk; t.tag = tag;
      exp_tile_q.push_back(t);
    end
    bus.start       = 1'b1;
    bus.start_ctrl  = ctrl;
    bus.start_base  = base;
    bus.start_chunk = chunk;
    tick();
    bus.start = 1'b0;
    check("req_latency", 64'(bus.rd_req_val), 64'd1);
    check("busy_after_start", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_idle(int budget, bit toggle_rdy, string name);
    int k = 0;
    while (bus.busy && k < budget) begin
      if (toggle_rdy) bus.rd_req_rdy = ~bus.rd_req_rdy;
      tick();
      k++;
    end
    n_cmp++;
    if (bus.busy) begin
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 after %0d cycles expected idle", name, budget);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int k, n;
    rst             = 1'b1;
    stray_req       = 1'b0;
    cur_row0        = '0;
    cur_tag         = 0;
    bus.start       = 1'b0;
    bus.start_ctrl  = 1'b0;
    bus.start_base  = '0;
    bus.start_chunk = '0;
    bus.rd_req_rdy  = 1'b1;
    bus.out_rdy     = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_req_val", 64'(bus.rd_req_val), 64'd0);
    check("rst_req_addr", bus.rd_req_addr, 64'd0);
    check("rst_out_val", 64'(bus.out_val), 64'd0);
    check("rst_tile_00", bus.out_elements[0][0], 64'd0);
    check("rst_tile_77", bus.out_elements[7][7], 64'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // T1/T2: chunk 3 of a 16x16 matrix at 0x1000, full-rate memory and consumer
    for (int r = 0; r < NMG; r++) exp_addr_q.push_back(64'h1440 + 64'(r) * 64'h80);
    issue_start(1'b1, 64'h1000, 64'd3, 0, 1'b1);
    wait_idle(100, 1'b0, "t1");
    check("t1_req_count_left", 64'(exp_addr_q.size()), 64'd0);
    check("t1_tile_count_left", 64'(exp_tile_q.size()), 64'd0);
    tick();

    // T3: request ready toggles every cycle
    push_model_addrs(64'h2000, 64'd2);
    issue_start(1'b0, 64'h2000, 64'd2, 1, 1'b1);
    wait_idle(200, 1'b1, "t3");
    bus.rd_req_rdy = 1'b1;
    check("t3_req_count_left", 64'(exp_addr_q.size()), 64'd0);
    tick();

    // T4: consumer stalls 5 cycles; a start in PRESENT is ignored
    bus.out_rdy = 1'b0;
    push_model_addrs(64'h3000, 64'd1);
    issue_start(1'b1, 64'h3000, 64'd1, 2, 1'b1);
    k = 0;
    while (!bus.out_val && k < 100) begin tick(); k++; end
    check("t4_out_val_seen", 64'(bus.out_val), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.start = 1'b1; bus.start_base = 64'h9999; bus.start_chunk = 64'd0;
      end else begin
        bus.start = 1'b0;
      end
      if (i == 2) check("t4_busy_in_present", 64'(bus.busy), 64'd1);
      tick();
    end
    check("t4_out_val_held", 64'(bus.out_val), 64'd1);
    bus.out_rdy = 1'b1;
    tick();
    check("t4_out_val_after_rdy", 64'(bus.out_val), 64'd0);
    check("t4_busy_after_rdy", 64'(bus.busy), 64'd0);
    repeat (3) tick();
    check("t4_no_stray_fetch", 64'(bus.rd_req_val), 64'd0);
    check("t4_idle", 64'(bus.busy), 64'd0);

    // T5: reset after 3 responses, stray responses drained in IDLE, then a clean fetch
    push_model_addrs(64'h4000, 64'd0);
    issue_start(1'b0, 64'h4000, 64'd0, 3, 1'b0);
    k = 0; n = 0;
    while (n < 3 && k < 100) begin
      tick();
      if (bus.rd_resp_val) n++;
      k++;
    end
    check("t5_three_responses", 64'(n), 64'd3);
    #1 rst = 1'b0;
    #1;
    check("t5_rst_busy", 64'(bus.busy), 64'd0);
    check("t5_rst_req_val", 64'(bus.rd_req_val), 64'd0);
    check("t5_rst_req_addr", bus.rd_req_addr, 64'd0);
    check("t5_rst_out_base", bus.out_base_addr, 64'd0);
    n_cmp++;
    if (bus.out_elements !== '0) begin
      n_fail++;
      $display("FAIL t5_rst_tile: got tile[0][0]=0x%0h expected all zero", bus.out_elements[0][0]);
    end
    exp_addr_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    k = 0;
    while (pend_q.size() > 0 && k < 20) begin tick(); k++; end
    repeat (2) tick();
    check("t5_stray_busy", 64'(bus.busy), 64'd0);
    n_cmp++;
    if (bus.out_elements !== '0) begin
      n_fail++;
      $display("FAIL t5_stray_tile: got tile[0][0]=0x%0h expected all zero", bus.out_elements[0][0]);
    end
    push_model_addrs(64'h5000, 64'd3);
    issue_start(1'b1, 64'h5000, 64'd3, 4, 1'b1);
    wait_idle(100, 1'b0, "t5");
    tick();

    // T6: chunk 0 at base 0, then a stray response in IDLE
    for (int r = 0; r < NMG; r++) exp_addr_q.push_back(64'(r) * 64'h80);
    issue_start(1'b1, 64'h0, 64'd0, 5, 1'b1);
    check("t6_first_addr", bus.rd_req_addr, 64'h0);
    wait_idle(100, 1'b0, "t6");
    tick();
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    repeat (2) tick();
    check("t6_stray_busy", 64'(bus.busy), 64'd0);
    check("t6_stray_out_val", 64'(bus.out_val), 64'd0);
    check("t6_stray_tile_00", bus.out_elements[0][0], exp_elem(5, 0, 0));
    check("t6_stray_tile_77", bus.out_elements[7][7], exp_elem(5, 7, 7));

    check("end_req_left", 64'(exp_addr_q.size()), 64'd0);
    check("end_tile_left", 64'(exp_tile_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
